ethernet_lane_aggregator: RTL and testbench

//  Parametrised lane-to-word packer for the Ethernet RX datapath. Packs RATIO

---
 rtl/ethernet_lane_aggregator.sv | 105 ++++++++++
 tb/tb_ethernet_lane_aggregator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_lane_aggregator.sv
// ethernet_lane_aggregator
//   Packs RATIO consecutive valid input lanes of IN_W bits into one output word
//   of IN_W*RATIO bits for the Ethernet RX datapath (MII nibbles or RMII dibits
//   into bytes). A frame that ends mid-word is flushed as a zero-padded partial
//   word whose filled-lane count is reported. There is no backpressure.
//
// Parameters
//   IN_W       bits per input lane (>=1)
//   RATIO      input lanes per output word (>=2)
//   LSB_FIRST  1: first lane lands in the lowest lane of out_data
//              0: first lane lands in the highest lane
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   in_data      input lane
//   in_valid     in_data valid this cycle
//   in_last      lane is the last of its frame (qualified by in_valid)
//   out_data     assembled word, held until the next emission
//   out_valid    one-cycle pulse per emitted word
//   out_last     emitted word ends the frame
//   out_lanes    lanes filled in the emitted word, 1..RATIO
//   out_partial  emitted word is a short final word of a frame
module ethernet_lane_aggregator #(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic [IN_W*RATIO-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [$clog2(RATIO+1)-1:0]   out_lanes,
  output logic                         out_partial
);

  localparam int OUT_W   = IN_W * RATIO;
  localparam int CNT_W   = $clog2(RATIO);
  localparam int LANES_W = $clog2(RATIO + 1);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] buffer;

  logic [CNT_W-1:0] lane_sel;
  logic [OUT_W-1:0] word_next;
  logic             word_full;
  logic             emit;

  // Physical lane slot for the current lane; MSB-first mode fills from the top.
  assign lane_sel  = LSB_FIRST ? cnt : (CNT_W'(RATIO - 1) - cnt);
  assign word_full = (cnt == CNT_W'(RATIO - 1));
  assign emit      = in_valid & (word_full | in_last);

  // Buffer with the incoming lane merged in. Slots not yet written are still
  // zero because the buffer is cleared on every emission, which yields the
  // zero padding of partial words for free.
  always_comb begin
    // NOTE: default-assign every always_comb output first so no path can
    // leave it unassigned and infer a latch.
    word_next = buffer;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) == lane_sel) begin
        word_next[i*IN_W +: IN_W] = in_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the assembly buffer is reset (not just the counter) because the
      // zero padding of partial words relies on it starting cleared.
      cnt         <= '0;
      buffer      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_lanes   <= '0;
      out_partial <= 1'b0;
    end else begin
      out_valid <= emit;
      if (in_valid) begin
        if (emit) begin
          // Clearing on the emitting edge lets the next word start in the
          // very next cycle with no bubble.
          out_data    <= word_next;
          out_last    <= in_last;
          out_lanes   <= LANES_W'(cnt) + LANES_W'(1);
          out_partial <= in_last & ~word_full;
          cnt         <= '0;
          buffer      <= '0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          buffer <= word_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ethernet_lane_aggregator.sv
// Testbench for ethernet_lane_aggregator. Three instances share clock and
// reset: u_mii (IN_W=4, RATIO=2, LSB first), u_msb (IN_W=4, RATIO=2, MSB
// first) and u_rmii (IN_W=2, RATIO=4, LSB first). A lane-list model predicts
// every output each cycle; directed literal checks pin the model.
module tb_ethernet_lane_aggregator;

  logic clk;
  logic reset;

  logic       iv [3];
  logic       il [3];
  logic [3:0] idat [3];

  logic [7:0] od0, od1, od2;
  logic       ov0, ov1, ov2;
  logic       ol0, ol1, ol2;
  logic [1:0] oln0, oln1;
  logic [2:0] oln2;
  logic       op0, op1, op2;

  ethernet_lane_aggregator #(.IN_W(4), .RATIO(2), .LSB_FIRST(1'b1)) u_mii (
    .clk(clk), .reset(reset),
    .in_data(idat[0]), .in_valid(iv[0]), .in_last(il[0]),
    .out_data(od0), .out_valid(ov0), .out_last(ol0),
    .out_lanes(oln0), .out_partial(op0)
  );

  ethernet_lane_aggregator #(.IN_W(4), .RATIO(2), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset),
    .in_data(idat[1]), .in_valid(iv[1]), .in_last(il[1]),
    .out_data(od1), .out_valid(ov1), .out_last(ol1),
    .out_lanes(oln1), .out_partial(op1)
  );

  logic [1:0] idat2;
  assign idat2 = idat[2][1:0];

  ethernet_lane_aggregator #(.IN_W(2), .RATIO(4), .LSB_FIRST(1'b1)) u_rmii (
    .clk(clk), .reset(reset),
    .in_data(idat2), .in_valid(iv[2]), .in_last(il[2]),
    .out_data(od2), .out_valid(ov2), .out_last(ol2),
    .out_lanes(oln2), .out_partial(op2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoring ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h (fields valid,last,partial,lanes[3],data[8])",
                  name, actual, expected);
  endtask

  // Packed view {valid, last, partial, lanes[2:0], data[7:0]}.
  function automatic logic [13:0] actual_of(input int k);
    case (k)
      0:       return {ov0, ol0, op0, {1'b0, oln0}, od0};
      1:       return {ov1, ol1, op1, {1'b0, oln1}, od1};
      default: return {ov2, ol2, op2, oln2, od2};
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Each instance collects its lanes in arrival order; when a word completes,
  // the word is built arithmetically from the list and the lane geometry.
  function automatic int p_in_w(input int k);  return (k == 2) ? 2 : 4; endfunction
  function automatic int p_ratio(input int k); return (k == 2) ? 4 : 2; endfunction
  function automatic bit p_lsb(input int k);   return (k != 1);         endfunction

  int         lanes_seen [3][8];
  int         n_seen [3];
  logic [13:0] exp_out [3];
  bit         live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        n_seen[k]  = 0;
        exp_out[k] = '0;
      end else begin
        exp_out[k][13] = 1'b0;
        if (iv[k]) begin
          lanes_seen[k][n_seen[k]] = int'(idat[k]) % (1 << p_in_w(k));
          n_seen[k]++;
          if (n_seen[k] == p_ratio(k) || il[k]) begin
            int word;
            int pos;
            word = 0;
            for (int i = 0; i < n_seen[k]; i++) begin
              pos  = p_lsb(k) ? i : (p_ratio(k) - 1 - i);
              word = word + lanes_seen[k][i] * (1 << (p_in_w(k) * pos));
            end
            exp_out[k] = {1'b1, il[k], (n_seen[k] < p_ratio(k)),
                          3'(n_seen[k]), 8'(word)};
            n_seen[k] = 0;
          end
        end
      end
    end
  end

  // One compare process: every cycle after reset has been seen, all outputs.
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model inst%0d t=%0t", k, $time),
              32'(actual_of(k)), 32'(exp_out[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int k, input logic [3:0] d, input logic last);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0;
      il[j] = 1'b0;
    end
    iv[k]   = 1'b1;
    il[k]   = last;
    idat[k] = d;
  endtask

  task automatic idle();
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0;
      il[j] = 1'b0;
    end
  endtask

  task automatic expect_out(input string name, input int k, input logic v,
                            input logic [7:0] d, input logic [2:0] ln,
                            input logic l, input logic p);
    check(name, 32'(actual_of(k)), 32'({v, l, p, ln, d}));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      iv[j] = 1'b0; il[j] = 1'b0; idat[j] = 4'h0;
    end
    repeat (2) @(posedge clk);
    live = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++)
      expect_out($sformatf("reset state inst%0d", k), k, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // 1: MII LSB-first, 0x5 then 0xD -> 0xD5 one clock after 0xD.
    send(0, 4'h5, 1'b0);
    send(0, 4'hD, 1'b0);
    idle();
    expect_out("t1 mii 0xD5", 0, 1'b1, 8'hD5, 3'd2, 1'b0, 1'b0);
    idle();
    expect_out("t1 pulse ends, data holds", 0, 1'b0, 8'hD5, 3'd2, 1'b0, 1'b0);

    // 2: MSB-first, 0x5 then 0xD -> 0x5D.
    send(1, 4'h5, 1'b0);
    send(1, 4'hD, 1'b0);
    idle();
    expect_out("t2 msb 0x5D", 1, 1'b1, 8'h5D, 3'd2, 1'b0, 1'b0);

    // 3: frame 1,2,3(last) -> 0x21 then partial 0x03; then 0xA,0xB -> 0xBA.
    send(0, 4'h1, 1'b0);
    send(0, 4'h2, 1'b0);
    send(0, 4'h3, 1'b1);
    expect_out("t3 full word 0x21", 0, 1'b1, 8'h21, 3'd2, 1'b0, 1'b0);
    idle();
    expect_out("t3 partial 0x03", 0, 1'b1, 8'h03, 3'd1, 1'b1, 1'b1);
    send(0, 4'hA, 1'b0);
    send(0, 4'hB, 1'b0);
    idle();
    expect_out("t3 next frame 0xBA", 0, 1'b1, 8'hBA, 3'd2, 1'b0, 1'b0);

    // 4: 0x7, three idle cycles, 0x8 -> single 0x87, nothing in the gap.
    send(0, 4'h7, 1'b0);
    repeat (3) begin
      idle();
      expect_out("t4 gap quiet", 0, 1'b0, 8'hBA, 3'd2, 1'b0, 1'b0);
    end
    send(0, 4'h8, 1'b0);
    idle();
    expect_out("t4 gapped word 0x87", 0, 1'b1, 8'h87, 3'd2, 1'b0, 1'b0);

    // 5: 0x7, reset, then 0x8,0x9 -> 0x98; outputs all zero after reset.
    send(0, 4'h7, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    iv[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++)
      expect_out($sformatf("t5 after reset inst%0d", k), k, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    send(0, 4'h8, 1'b0);
    send(0, 4'h9, 1'b0);
    idle();
    expect_out("t5 post-reset 0x98", 0, 1'b1, 8'h98, 3'd2, 1'b0, 1'b0);

    // 6: RMII dibits 1,2,3,0 -> 0x39, four lanes.
    send(2, 4'h1, 1'b0);
    send(2, 4'h2, 1'b0);
    send(2, 4'h3, 1'b0);
    send(2, 4'h0, 1'b0);
    idle();
    expect_out("t6 rmii 0x39", 2, 1'b1, 8'h39, 3'd4, 1'b0, 1'b0);

    // Extra boundaries: single-lane frames back to back (consecutive pulses).
    send(0, 4'h1, 1'b1);
    send(0, 4'h2, 1'b1);
    expect_out("b2b first 0x01", 0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b1);
    idle();
    expect_out("b2b second 0x02", 0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b1);

    // in_last without in_valid is ignored.
    @(negedge clk);
    il[0] = 1'b1;
    send(0, 4'h5, 1'b0);
    send(0, 4'h6, 1'b0);
    idle();
    expect_out("stray last ignored 0x65", 0, 1'b1, 8'h65, 3'd2, 1'b0, 1'b0);

    // MSB-first partial lands in the top lane; RMII partial of two dibits.
    send(1, 4'h5, 1'b1);
    idle();
    expect_out("msb partial 0x50", 1, 1'b1, 8'h50, 3'd1, 1'b1, 1'b1);
    send(2, 4'h3, 1'b0);
    send(2, 4'h1, 1'b1);
    idle();
    expect_out("rmii partial 0x07", 2, 1'b1, 8'h07, 3'd2, 1'b1, 1'b1);
    send(2, 4'h2, 1'b0);
    send(2, 4'h1, 1'b0);
    send(2, 4'h0, 1'b0);
    send(2, 4'h3, 1'b1);
    idle();
    expect_out("rmii full last 0xC6", 2, 1'b1, 8'hC6, 3'd4, 1'b1, 1'b0);

    repeat (2) idle();
    live = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
